// File: rtl/lut4_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut4_loader_pkg
// Description : Shared constants, header field positions and FSM state
//               encoding for the LUT4 frame configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package lut4_loader_pkg;

    localparam int         LUT_CFG_W     = 19;
    localparam logic [7:0] SYNC_BYTE     = 8'hFA;
    localparam int         HDR_SYNC_LSB  = 24;
    localparam int         HDR_START_LSB = 16;
    localparam int         HDR_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
`ifdef LUT4_LOADER_CHECKSUM_EN
        ST_CHK    = 3'd3,
`endif
        ST_COMMIT = 3'd4,
        ST_ERR    = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/lut4_cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module      : lut4_cfg_shadow
// Description : Per-BEL shadow register file plus the active configuration
//               register; a commit copies only BELs start..start+count-1.
// Revision    : 1.0 - initial release
// ============================================================================
module lut4_cfg_shadow #(
    parameter int NUM_LUTS = 8,
    parameter int CFG_W    = 19,
    parameter int IDX_W    = 3
) (
    input  logic                      UserCLK,
    input  logic                      RST,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [CFG_W-1:0]          wr_data,
    input  logic                      commit,
    input  logic [7:0]                commit_start,
    input  logic [7:0]                commit_count,
    output logic [NUM_LUTS*CFG_W-1:0] active_cfg
);

    logic [8:0] w_commit_end;

    assign w_commit_end = {1'b0, commit_start} + {1'b0, commit_count};

    for (genvar k = 0; k < NUM_LUTS; k++) begin : g_bel
        logic [CFG_W-1:0] r_shadow;
        logic [CFG_W-1:0] r_active;
        logic             w_in_window;

        assign w_in_window = (9'(k) >= {1'b0, commit_start}) && (9'(k) < w_commit_end);

        always_ff @(posedge UserCLK) begin
            if (RST) begin
                r_shadow <= '0;
                r_active <= '0;
            end else begin
                if (wr_en && (wr_idx == IDX_W'(k)))
                    r_shadow <= wr_data;
                if (commit && w_in_window)
                    r_active <= r_shadow;
            end
        end

        assign active_cfg[k*CFG_W +: CFG_W] = r_active;
    end

endmodule
`default_nettype wire

// File: rtl/lut4_frame_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut4_frame_config_loader
// Description : Header/data stream loader committing LUT4 BEL configuration
//               atomically. Optional trailer checksum: LUT4_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lut4_frame_config_loader
    import lut4_loader_pkg::*;
#(
    parameter int NumLUTs      = 8,
    parameter int NoConfigBits = LUT_CFG_W
) (
    input  logic                            UserCLK,
    input  logic                            RST,
    input  logic [31:0]                     in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NumLUTs*NoConfigBits-1:0] ConfigBits,
    output logic                            EN_gate,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    input  logic                            err_clr
);

    localparam int IDX_W = (NumLUTs > 1) ? $clog2(NumLUTs) : 1;

    loader_state_t r_state;
    logic          r_in_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_en_gate;
    logic [7:0]    r_start;
    logic [7:0]    r_count;
    logic [7:0]    r_cnt;
`ifdef LUT4_LOADER_CHECKSUM_EN
    logic [NoConfigBits-1:0] r_xor;
`endif

    logic       w_xfer;
    logic [7:0] w_hdr_sync;
    logic [7:0] w_hdr_start;
    logic [7:0] w_hdr_count;
    logic       w_hdr_ok;
    logic       w_last_word;
    logic       w_wr_en;
    logic       w_commit;

    assign w_xfer      = in_valid & r_in_ready;
    assign w_hdr_sync  = in_data[HDR_SYNC_LSB  +: 8];
    assign w_hdr_start = in_data[HDR_START_LSB +: 8];
    assign w_hdr_count = in_data[HDR_COUNT_LSB +: 8];
    // 9-bit sum so a large start index cannot wrap back into range
    assign w_hdr_ok    = (w_hdr_sync == SYNC_BYTE) && (w_hdr_count != 8'd0) &&
                         (({1'b0, w_hdr_start} + {1'b0, w_hdr_count}) <= 9'(NumLUTs));
    assign w_last_word = (r_cnt == (r_count - 8'd1));
    assign w_wr_en     = (r_state == ST_DATA) && w_xfer;
    assign w_commit    = (r_state == ST_COMMIT);

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_en_gate  <= 1'b1;
            r_start    <= 8'd0;
            r_count    <= 8'd0;
            r_cnt      <= 8'd0;
`ifdef LUT4_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_HDR;
                    r_in_ready <= 1'b1;
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        if (w_hdr_ok) begin
                            r_start <= w_hdr_start;
                            r_count <= w_hdr_count;
                            r_cnt   <= 8'd0;
                            r_busy  <= 1'b1;
                            r_state <= ST_DATA;
`ifdef LUT4_LOADER_CHECKSUM_EN
                            r_xor   <= '0;
`endif
                        end else begin
                            r_state    <= ST_ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                            r_en_gate  <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 8'd1;
`ifdef LUT4_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ in_data[NoConfigBits-1:0];
                        if (w_last_word)
                            r_state <= ST_CHK;
`else
                        if (w_last_word) begin
                            r_state    <= ST_COMMIT;
                            r_in_ready <= 1'b0;
                            r_en_gate  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef LUT4_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        r_en_gate  <= 1'b0;
                        if (in_data[NoConfigBits-1:0] == r_xor) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    r_state   <= ST_IDLE;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_en_gate <= 1'b1;
                end
                ST_ERR: begin
                    if (err_clr) begin
                        r_state   <= ST_IDLE;
                        r_err     <= 1'b0;
                        r_en_gate <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    lut4_cfg_shadow #(
        .NUM_LUTS (NumLUTs),
        .CFG_W    (NoConfigBits),
        .IDX_W    (IDX_W)
    ) u_shadow (
        .UserCLK      (UserCLK),
        .RST          (RST),
        .wr_en        (w_wr_en),
        .wr_idx       (IDX_W'(r_start + r_cnt)),
        .wr_data      (in_data[NoConfigBits-1:0]),
        .commit       (w_commit),
        .commit_start (r_start),
        .commit_count (r_count),
        .active_cfg   (ConfigBits)
    );

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign EN_gate  = r_en_gate;

endmodule
`default_nettype wire

// File: tb/tb_lut4_frame_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut4_frame_config_loader
// Description : Randomized self-checking bench with a frame-level reference
//               model of the loader's shadow and active configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut4_frame_config_loader;

    localparam int NL = 8;
    localparam int CW = 19;

    logic            UserCLK;
    logic            RST;
    logic [31:0]     in_data;
    logic            in_valid;
    logic            in_ready;
    logic [NL*CW-1:0] ConfigBits;
    logic            EN_gate;
    logic            busy;
    logic            done;
    logic            err;
    logic            err_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0] model_shadow [NL];
    logic [CW-1:0] model_active [NL];
    logic [31:0]   frame_data   [NL];

    lut4_frame_config_loader #(.NumLUTs(NL), .NoConfigBits(CW)) dut (
        .UserCLK    (UserCLK),
        .RST        (RST),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ConfigBits (ConfigBits),
        .EN_gate    (EN_gate),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NL*CW-1:0] model_bus();
        logic [NL*CW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*CW +: CW] = model_active[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NL; k++) begin
            model_shadow[k] = '0;
            model_active[k] = '0;
        end
    endtask

    // Called and returns at a negedge; the word transfers on the posedge in between.
    task automatic send_word(input logic [31:0] w, input int stall);
        int n;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b0;
            @(negedge UserCLK);
        end
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge UserCLK);
            n++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge UserCLK);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic expect_err_and_clear(input string tag);
        check_eq({tag, "_err"}, err, 1);
        check_eq({tag, "_ready"}, in_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_en"}, EN_gate, 0);
        check_eq({tag, "_done"}, done, 0);
        repeat (3) @(negedge UserCLK);
        check_eq({tag, "_hold"}, err, 1);
        check_eq({tag, "_cfg"}, ConfigBits, model_bus());
        err_clr = 1'b1;
        @(negedge UserCLK);
        err_clr = 1'b0;
        check_eq({tag, "_clr"}, err, 0);
        check_eq({tag, "_clr_en"}, EN_gate, 1);
    endtask

    task automatic run_frame(input logic [7:0] sync, input int s, input int c,
                             input int stall, input bit bad_sum);
        logic [CW-1:0] x;
        bit hdr_ok;
        hdr_ok = (sync == 8'hFA) && (c != 0) && (s + c <= NL);
        send_word({sync, 8'(s), 8'(c), 8'(($urandom))}, stall);
        if (!hdr_ok) begin
            expect_err_and_clear("hdr");
            return;
        end
        check_eq("busy_frame", busy, 1);
        x = '0;
        for (int i = 0; i < c; i++) begin
            send_word(frame_data[i], stall);
            model_shadow[s+i] = frame_data[i][CW-1:0];
            x ^= frame_data[i][CW-1:0];
        end
`ifdef LUT4_LOADER_CHECKSUM_EN
        send_word({13'($urandom), bad_sum ? (x ^ 19'd1) : x}, stall);
        if (bad_sum) begin
            expect_err_and_clear("chk");
            return;
        end
`else
        if (bad_sum) x = '0;
`endif
        check_eq("commit_en_low", EN_gate, 0);
        check_eq("commit_ready", in_ready, 0);
        check_eq("commit_nodone", done, 0);
        check_eq("commit_cfg_old", ConfigBits, model_bus());
        for (int i = s; i < s + c; i++) model_active[i] = model_shadow[i];
        @(negedge UserCLK);
        check_eq("done_pulse", done, 1);
        check_eq("done_noerr", err, 0);
        check_eq("done_busy", busy, 0);
        check_eq("done_en", EN_gate, 1);
        check_eq("cfg_commit", ConfigBits, model_bus());
        @(negedge UserCLK);
        check_eq("done_single", done, 0);
    endtask

    task automatic random_frame();
        int s, c, stall;
        logic [7:0] sync;
        s = $urandom_range(0, NL - 1);
        c = $urandom_range(1, NL - s);
        sync = 8'hFA;
        case ($urandom_range(0, 9))
            0: sync = 8'(($urandom_range(0, 254) + 8'hFB));
            1: c = NL - s + 1 + $urandom_range(0, 3);
            2: c = 0;
            default: ;
        endcase
        stall = $urandom_range(0, 2);
        for (int i = 0; i < NL; i++) frame_data[i] = $urandom;
        run_frame(sync, s, c, stall, 1'b0);
    endtask

    initial begin
        RST      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge UserCLK);
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_en", EN_gate, 1);
        check_eq("rst_cfg", ConfigBits, 0);
        RST = 1'b0;

        // Basic full-tile commit
        for (int k = 0; k < NL; k++) frame_data[k] = 32'(k) + 32'h8000 | 32'h10000;
        run_frame(8'hFA, 0, 8, 0, 1'b0);
        for (int k = 0; k < NL; k++) check_eq("basic_bel", ConfigBits[k*CW +: CW], 19'h18000 + 19'(k));

        // Partial frame over a preloaded tile
        for (int k = 0; k < NL; k++) frame_data[k] = 32'h7FFFF;
        run_frame(8'hFA, 0, 8, 0, 1'b0);
        frame_data[0] = 32'h00AAA;
        frame_data[1] = 32'h00555;
        run_frame(8'hFA, 3, 2, 0, 1'b0);
        check_eq("partial_bel3", ConfigBits[3*CW +: CW], 19'h00AAA);
        check_eq("partial_bel4", ConfigBits[4*CW +: CW], 19'h00555);
        check_eq("partial_bel5", ConfigBits[5*CW +: CW], 19'h7FFFF);

        // Range error, then a valid frame
        run_frame(8'hFA, 7, 2, 0, 1'b0);
        for (int k = 0; k < NL; k++) frame_data[k] = $urandom;
        run_frame(8'hFA, 1, 5, 0, 1'b0);

        // Bad sync, then a frame with valid toggling
        run_frame(8'hFB, 0, 1, 0, 1'b0);
        for (int k = 0; k < NL; k++) frame_data[k] = $urandom;
        run_frame(8'hFA, 0, 8, 1, 1'b0);

`ifdef LUT4_LOADER_CHECKSUM_EN
        for (int k = 0; k < NL; k++) frame_data[k] = $urandom;
        run_frame(8'hFA, 2, 4, 0, 1'b1);
`endif

        for (int f = 0; f < 20; f++) random_frame();

        // Reset in the middle of a frame
        send_word(32'hFA000800, 0);
        for (int i = 0; i < 3; i++) send_word($urandom, 0);
        RST = 1'b1;
        @(negedge UserCLK);
        RST = 1'b0;
        model_reset();
        check_eq("midrst_cfg", ConfigBits, 0);
        check_eq("midrst_ready", in_ready, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_err", err, 0);
        check_eq("midrst_en", EN_gate, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("midrst_nodone", done, 0);
            @(negedge UserCLK);
        end
        for (int k = 0; k < NL; k++) frame_data[k] = $urandom;
        run_frame(8'hFA, 4, 3, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
